// File: rtl/sync_fifo_flagged.sv
// sync_fifo_flagged: single-clock FIFO with registered read data, fill count, threshold flags and sticky errors
module sync_fifo_flagged #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [DSIZE-1:0] wdata,
  input  logic             ren,
  output logic [DSIZE-1:0] rdata,
  output logic             rvalid,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);
  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] AF = AFULL_TH[ASIZE:0];
  localparam logic [ASIZE:0] AE = AEMPTY_TH[ASIZE:0];
  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0] wptr, rptr;
  logic wr_ok, rd_ok;
  // Flags decode only from registered pointers, so no wen/ren-to-flag path exists
  assign count         = wptr - rptr;
  assign rempty        = wptr == rptr;
  assign wfull         = (wptr[ASIZE] != rptr[ASIZE]) && (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
  assign walmost_full  = count >= AF;
  assign ralmost_empty = count <= AE;
  assign wr_ok         = wen && !wfull;
  assign rd_ok         = ren && !rempty;
  always_ff @(posedge clk)
    if (wr_ok) mem[wptr[ASIZE-1:0]] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      rdata     <= '0;
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr      <= wptr + {{ASIZE{1'b0}}, wr_ok};
      rptr      <= rptr + {{ASIZE{1'b0}}, rd_ok};
      rvalid    <= rd_ok;
      rdata     <= rd_ok ? mem[rptr[ASIZE-1:0]] : rdata;
      overflow  <= (overflow && !clr_err) || (wen && wfull);
      underflow <= (underflow && !clr_err) || (ren && rempty);
    end
endmodule

// File: tb/tb_sync_fifo_flagged.sv
// tb_sync_fifo_flagged: directed scenario tests for sync_fifo_flagged with inline checks
module tb_sync_fifo_flagged;
  logic       clk, rst, wen, ren, clr_err;
  logic [7:0] wdata, rdata;
  logic       rvalid, wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
  logic [4:0] count;
  int total = 0;
  int bad = 0;

  sync_fifo_flagged #(.DSIZE(8), .ASIZE(4), .AFULL_TH(12), .AEMPTY_TH(2)) dut (
    .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren), .rdata(rdata),
    .rvalid(rvalid), .wfull(wfull), .rempty(rempty), .walmost_full(walmost_full),
    .ralmost_empty(ralmost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL %s count got=%0d exp=0", tag, count); end
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL %s rempty got=%b exp=1", tag, rempty); end
    total++; if (ralmost_empty !== 1'b1) begin bad++; $display("FAIL %s ralmost_empty got=%b exp=1", tag, ralmost_empty); end
    total++; if (wfull !== 1'b0) begin bad++; $display("FAIL %s wfull got=%b exp=0", tag, wfull); end
    total++; if (walmost_full !== 1'b0) begin bad++; $display("FAIL %s walmost_full got=%b exp=0", tag, walmost_full); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL %s rdata got=%h exp=00", tag, rdata); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL %s rvalid got=%b exp=0", tag, rvalid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL %s overflow got=%b exp=0", tag, overflow); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL %s underflow got=%b exp=0", tag, underflow); end
  endtask

  task automatic test_reset;
    rst = 1'b1; wen = 1'b0; ren = 1'b0; clr_err = 1'b0; wdata = 8'h00;
    step; step;
    rst = 1'b0;
    step; step;
    check_reset_state("reset");
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 16; i++) begin
      wen = 1'b1; wdata = 8'(i);
      step;
      total++; if (count !== 5'(i + 1)) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
      total++; if (walmost_full !== (i + 1 >= 12)) begin bad++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, walmost_full, i + 1 >= 12); end
      total++; if (wfull !== (i == 15)) begin bad++; $display("FAIL fill_wfull[%0d] got=%b exp=%b", i, wfull, i == 15); end
    end
    wdata = 8'hAA;
    step;
    wen = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", count); end
    for (int i = 0; i < 16; i++) begin
      ren = 1'b1;
      step;
      total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL drain_rvalid[%0d] got=%b exp=1", i, rvalid); end
      total++; if (rdata !== 8'(i)) begin bad++; $display("FAIL drain_rdata[%0d] got=%h exp=%h", i, rdata, 8'(i)); end
      total++; if (ralmost_empty !== (15 - i <= 2)) begin bad++; $display("FAIL drain_aempty[%0d] got=%b exp=%b", i, ralmost_empty, 15 - i <= 2); end
    end
    ren = 1'b0;
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL drain_rempty got=%b exp=1", rempty); end
    step;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL idle_rvalid got=%b exp=0", rvalid); end
    total++; if (rdata !== 8'h0F) begin bad++; $display("FAIL idle_rdata_hold got=%h exp=0f", rdata); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_underflow;
    ren = 1'b1;
    step;
    ren = 1'b0;
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL udf_set got=%b exp=1", underflow); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL udf_rvalid got=%b exp=0", rvalid); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL udf_count got=%0d exp=0", count); end
    clr_err = 1'b1;
    step;
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL udf_clear got=%b exp=0", underflow); end
    ren = 1'b1;
    step;
    ren = 1'b0; clr_err = 1'b0;
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL udf_set_wins got=%b exp=1", underflow); end
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
  endtask

  task automatic test_boundaries;
    for (int i = 0; i < 16; i++) begin
      wen = 1'b1; wdata = 8'(i);
      step;
    end
    wen = 1'b1; ren = 1'b1; wdata = 8'h55;
    step;
    wen = 1'b0; ren = 1'b0;
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL full_rw_rdata got=%h exp=00", rdata); end
    total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL full_rw_rvalid got=%b exp=1", rvalid); end
    total++; if (count !== 5'd15) begin bad++; $display("FAIL full_rw_count got=%0d exp=15", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_rw_ovf got=%b exp=1", overflow); end
    for (int i = 1; i < 16; i++) begin
      ren = 1'b1;
      step;
      total++; if (rdata !== 8'(i)) begin bad++; $display("FAIL full_rw_drain[%0d] got=%h exp=%h", i, rdata, 8'(i)); end
    end
    ren = 1'b0; clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    wen = 1'b1; ren = 1'b1; wdata = 8'h33;
    step;
    wen = 1'b0; ren = 1'b0;
    total++; if (count !== 5'd1) begin bad++; $display("FAIL empty_rw_count got=%0d exp=1", count); end
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL empty_rw_udf got=%b exp=1", underflow); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL empty_rw_rvalid got=%b exp=0", rvalid); end
    ren = 1'b1;
    step;
    ren = 1'b0;
    total++; if (rdata !== 8'h33) begin bad++; $display("FAIL empty_rw_read got=%h exp=33", rdata); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL empty_rw_after got=%0d exp=0", count); end
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 5; i++) begin
      wen = 1'b1; wdata = 8'(8'h80 + i);
      step;
    end
    for (int i = 0; i < 40; i++) begin
      wen = 1'b1; ren = 1'b1; wdata = 8'(8'h85 + i);
      step;
      total++; if (count !== 5'd5) begin bad++; $display("FAIL wrap_count[%0d] got=%0d exp=5", i, count); end
      total++; if (rdata !== 8'(8'h80 + i)) begin bad++; $display("FAIL wrap_rdata[%0d] got=%h exp=%h", i, rdata, 8'(8'h80 + i)); end
    end
    wen = 1'b0;
    for (int i = 40; i < 45; i++) begin
      ren = 1'b1;
      step;
      total++; if (rdata !== 8'(8'h80 + i)) begin bad++; $display("FAIL wrap_tail[%0d] got=%h exp=%h", i, rdata, 8'(8'h80 + i)); end
    end
    ren = 1'b0;
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", rempty); end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 9; i++) begin
      wen = 1'b1; wdata = 8'(8'hC0 + i);
      step;
    end
    wen = 1'b0; ren = 1'b1;
    step;
    ren = 1'b0;
    total++; if (count !== 5'd8) begin bad++; $display("FAIL pre_rst_count got=%0d exp=8", count); end
    #3 rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    #1 rst = 1'b0;
    step;
    wen = 1'b1; wdata = 8'h77;
    step;
    wen = 1'b0; ren = 1'b1;
    step;
    ren = 1'b0;
    total++; if (rdata !== 8'h77) begin bad++; $display("FAIL post_rst_rdata got=%h exp=77", rdata); end
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL post_rst_empty got=%b exp=1", rempty); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL post_rst_count got=%0d exp=0", count); end
  endtask

  initial begin
    test_reset;
    test_fill_drain;
    test_underflow;
    test_boundaries;
    test_wrap;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
